// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: shares the data-memory/MMIO port between requester A (priority) and B (starvation guard).
// Optional build macro DMEM_ARB_B_RDONLY_EN: port B becomes read-only and dropped B writes are counted.
module sc_dmem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic [31:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic [31:0] b_rdata,
  output logic        b_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output logic        busy
`ifdef DMEM_ARB_B_RDONLY_EN
  ,
  output logic [7:0]  b_wr_drop_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAT_INIT   = 2'(RD_LAT - 1);

  logic [1:0]  r_state;
  logic        r_owner_b;
  logic [3:0]  r_starve;
  logic [1:0]  r_lat;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic        r_a_rvalid;
  logic        r_b_rvalid;

  logic        w_idle;
  logic        w_access;
  logic        w_start;
  logic        w_pick_b;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_wr_en;
  logic        w_rd_done;

  assign w_idle   = (r_state == S_IDLE);
  assign w_access = (r_state == S_ACCESS);
  assign w_start  = w_idle && (a_req || b_req);

  // B wins only when A is absent or A has starved B for STARVE_MAX grants
  assign w_pick_b    = b_req && (!a_req || (r_starve == STARVE_LIM));
  assign w_sel_we    = w_pick_b ? b_we    : a_we;
  assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;

  assign w_rd_done = (r_state == S_WAIT) && (r_lat == 2'd0);

`ifdef DMEM_ARB_B_RDONLY_EN
  assign w_wr_en = r_we && !r_owner_b;
`else
  assign w_wr_en = r_we;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_owner_b  <= 1'b0;
      r_lat      <= 2'd0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= 32'd0;
      r_b_rdata  <= 32'd0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_owner_b <= w_pick_b;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_IDLE;
          end else begin
            r_lat   <= LAT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rd_done) begin
            if (r_owner_b) begin
              r_b_rdata  <= mem_dout;
              r_b_rvalid <= 1'b1;
            end else begin
              r_a_rdata  <= mem_dout;
              r_a_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_lat <= r_lat - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Access attributes are only observed while in ACCESS, so they carry no reset
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr & 32'hFFFF_FFFC;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_starve <= 4'd0;
    end else if (!b_req) begin
      r_starve <= 4'd0;
    end else if (w_start) begin
      if (w_pick_b) begin
        r_starve <= 4'd0;
      end else if (r_starve != STARVE_LIM) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

`ifdef DMEM_ARB_B_RDONLY_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= 8'd0;
    end else if (w_access && r_owner_b && r_we && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign b_wr_drop_cnt = r_drop_cnt;
`endif

  assign a_gnt    = w_access && !r_owner_b;
  assign b_gnt    = w_access &&  r_owner_b;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign mem_addr = w_access ? r_addr : 32'd0;
  assign mem_din  = (w_access && r_we) ? r_wdata : 32'd0;
  assign mem_we   = w_access && w_wr_en;
  assign busy     = !w_idle;

endmodule
